// File: rtl/wb_multilane.sv
// Multi-lane NTT/INTT butterfly write-back stage.
// Accepted beats travel through one uniform delay pipeline, then a registered
// output stage fans each word out to the register file and, for last-stage
// beats, to BRAM. Last-stage INTT words are scaled by NINV mod Q on the way out.
// A running count of last-stage words written signals transform completion.
module wb_multilane #(
  parameter int unsigned LANES       = 1,
  parameter int unsigned DW          = 12,
  parameter int unsigned AW          = 8,
  parameter int unsigned BW          = 16,
  parameter int unsigned Q           = 3329,
  parameter int unsigned NINV        = 3303,
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned NCOEF       = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_stall,
  input  logic                    i_last,
  input  logic                    i_sel,
  input  logic [2*LANES*AW-1:0]   i_addr,
  input  logic [2*LANES*DW-1:0]   i_data,
  output logic [2*LANES-1:0]      rf_we,
  output logic [2*LANES*AW-1:0]   rf_addr,
  output logic [2*LANES*DW-1:0]   rf_din,
  output logic [2*LANES-1:0]      bram_we,
  output logic [2*LANES*AW-1:0]   bram_addr,
  output logic [2*LANES*BW-1:0]   bram_din,
  output logic                    o_done,
  output logic                    o_busy,
  output logic [AW:0]             o_wcount
);

  localparam int unsigned S = 2 * LANES;
  // Input capture register plus MUL_LATENCY delay stages ahead of the output register.
  localparam int unsigned D = MUL_LATENCY + 1;
  localparam logic [2*DW-1:0] Q_W     = (2*DW)'(Q);
  localparam logic [2*DW-1:0] NINV_W  = (2*DW)'(NINV);
  localparam logic [AW:0]     STEP_W  = (AW+1)'(S);
  localparam logic [AW:0]     NCOEF_W = (AW+1)'(NCOEF);

  // Delay pipeline: per-stage valid/control bits and payload.
  logic [D-1:0]    v_q;
  logic [D-1:0]    last_q;
  logic [D-1:0]    sel_q;
  logic [S*AW-1:0] addr_q [D];
  logic [S*DW-1:0] data_q [D];

  // Output register stage.
  logic            out_v_q;
  logic [S-1:0]    rf_we_q;
  logic [S-1:0]    bram_we_q;
  logic [S*AW-1:0] out_addr_q;
  logic [S*DW-1:0] rf_din_q;
  logic [S*BW-1:0] bram_din_q;
  logic [AW:0]     wcount_q;
  logic            done_q;

  // Next-state values for the output stage.
  logic [S*DW-1:0] rf_din_d;
  logic [S*BW-1:0] bram_din_d;
  logic [AW:0]     wcount_d;
  logic            scale_en;
  logic [DW-1:0]   word;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   res;

  // Per-word output data: INTT last-stage words are scaled, everything else passes through.
  always_comb begin
    scale_en   = sel_q[D-1] & last_q[D-1];
    rf_din_d   = '0;
    bram_din_d = '0;
    word       = '0;
    prod       = '0;
    res        = '0;
    for (int unsigned j = 0; j < S; j++) begin
      word = data_q[D-1][j*DW +: DW];
      prod = (2*DW)'(word) * NINV_W;
      res  = scale_en ? DW'(prod % Q_W) : word;
      rf_din_d[j*DW +: DW]   = res;
      bram_din_d[j*BW +: BW] = BW'(res);
    end
  end

  // Completion counter: a full count is cleared on the following advance, and a
  // last-stage beat leaving in that same advance starts the next transform's count.
  always_comb begin
    wcount_d = ((wcount_q == NCOEF_W) ? '0 : wcount_q)
             + ((v_q[D-1] & last_q[D-1]) ? STEP_W : '0);
  end

  // Pipeline advance, output registration and counters; a stall freezes all
  // state and only drops the write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q        <= '0;
      last_q     <= '0;
      sel_q      <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      out_v_q    <= 1'b0;
      rf_we_q    <= '0;
      bram_we_q  <= '0;
      out_addr_q <= '0;
      rf_din_q   <= '0;
      bram_din_q <= '0;
      wcount_q   <= '0;
      done_q     <= 1'b0;
    end else if (i_stall) begin
      rf_we_q   <= '0;
      bram_we_q <= '0;
    end else begin
      v_q[0] <= i_valid;
      if (i_valid) begin
        last_q[0] <= i_last;
        sel_q[0]  <= i_sel;
        addr_q[0] <= i_addr;
        data_q[0] <= i_data;
      end
      for (int unsigned i = 1; i < D; i++) begin
        v_q[i]    <= v_q[i-1];
        last_q[i] <= last_q[i-1];
        sel_q[i]  <= sel_q[i-1];
        addr_q[i] <= addr_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      out_v_q   <= v_q[D-1];
      rf_we_q   <= {S{v_q[D-1]}};
      bram_we_q <= {S{v_q[D-1] & last_q[D-1]}};
      if (v_q[D-1]) begin
        out_addr_q <= addr_q[D-1];
        rf_din_q   <= rf_din_d;
        bram_din_q <= bram_din_d;
      end
      wcount_q <= wcount_d;
      done_q   <= (wcount_q == NCOEF_W);
    end
  end

  assign o_ready   = ~i_stall;
  assign rf_we     = rf_we_q;
  assign rf_addr   = out_addr_q;
  assign rf_din    = rf_din_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = out_addr_q;
  assign bram_din  = bram_din_q;
  assign o_done    = done_q;
  assign o_busy    = (|v_q) | out_v_q;
  assign o_wcount  = wcount_q;

endmodule

// File: tb/tb_wb_multilane.sv
// Self-checking bench for wb_multilane (single lane, default parameters).
module tb_wb_multilane;

  localparam int AW = 8;
  localparam int DW = 12;
  localparam int BW = 16;
  localparam int ML = 4;
  localparam int NC = 256;
  localparam int QV = 3329;
  localparam int NI = 3303;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_valid = 1'b0;
  logic            i_stall = 1'b0;
  logic            i_last = 1'b0;
  logic            i_sel = 1'b0;
  logic [2*AW-1:0] i_addr = '0;
  logic [2*DW-1:0] i_data = '0;
  logic            o_ready;
  logic [1:0]      rf_we;
  logic [2*AW-1:0] rf_addr;
  logic [2*DW-1:0] rf_din;
  logic [1:0]      bram_we;
  logic [2*AW-1:0] bram_addr;
  logic [2*BW-1:0] bram_din;
  logic            o_done;
  logic            o_busy;
  logic [AW:0]     o_wcount;

  wb_multilane #(
    .LANES(1), .DW(DW), .AW(AW), .BW(BW), .Q(QV), .NINV(NI),
    .MUL_LATENCY(ML), .NCOEF(NC)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_stall(i_stall), .i_last(i_last), .i_sel(i_sel),
    .i_addr(i_addr), .i_data(i_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .o_done(o_done), .o_busy(o_busy), .o_wcount(o_wcount)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int scale(input int d);
    return (d * NI) % QV;
  endfunction

  // Reference model: each accepted beat is due a fixed number of non-stalled
  // edges after acceptance; writes and the completion counter follow from that.
  typedef struct {
    int due; bit last; bit sel; int au; int ad; int du; int dd;
  } beat_t;
  beat_t infl[$];
  int adv = 0;
  bit m_we = 0, m_bwe = 0, m_outv = 0, m_done = 0;
  int m_wc = 0, m_au = 0, m_ad = 0, m_du = 0, m_dd = 0;

  task automatic model_step();
    beat_t b;
    bit emit;
    b = '{0, 0, 0, 0, 0, 0, 0};
    cyc++;
    if (rst) begin
      infl.delete();
      m_we = 0; m_bwe = 0; m_outv = 0; m_done = 0; m_wc = 0;
    end else if (i_stall) begin
      m_we = 0; m_bwe = 0;
    end else begin
      adv++;
      emit = 0;
      if (infl.size() > 0 && infl[0].due == adv) begin
        b = infl.pop_front();
        emit = 1;
      end
      m_done = (m_wc == NC);
      if (m_done) m_wc = 0;
      m_we = emit; m_bwe = emit && b.last; m_outv = emit;
      if (emit) begin
        m_au = b.au; m_ad = b.ad;
        m_du = (b.sel && b.last) ? scale(b.du) : b.du;
        m_dd = (b.sel && b.last) ? scale(b.dd) : b.dd;
        if (b.last) m_wc += 2;
      end
      if (i_valid) begin
        b.due = adv + ML + 1; b.last = i_last; b.sel = i_sel;
        b.au = int'(i_addr[AW-1:0]); b.ad = int'(i_addr[2*AW-1:AW]);
        b.du = int'(i_data[DW-1:0]); b.dd = int'(i_data[2*DW-1:DW]);
        infl.push_back(b);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    logic [2*AW-1:0] ea;
    logic [2*DW-1:0] ed;
    logic [2*BW-1:0] eb;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("rf_we", rf_we, {m_we, m_we});
        check("bram_we", bram_we, {m_bwe, m_bwe});
        check("o_done", o_done, m_done);
        check("o_wcount", o_wcount, m_wc);
        check("o_busy", o_busy, (infl.size() != 0) || m_outv);
        if (m_we) begin
          ea = {AW'(m_ad), AW'(m_au)};
          ed = {DW'(m_dd), DW'(m_du)};
          eb = {BW'(m_dd), BW'(m_du)};
          check("rf_addr", rf_addr, ea);
          check("rf_din", rf_din, ed);
          if (m_bwe) begin
            check("bram_addr", bram_addr, ea);
            check("bram_din", bram_din, eb);
          end
        end
        if (o_done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic drive(input bit v, input bit st, input bit la, input bit se,
                       input int au, input int ad, input int du, input int dd);
    @(posedge clk);
    #2;
    i_valid = v; i_stall = st; i_last = la; i_sel = se;
    i_addr = {AW'(ad), AW'(au)};
    i_data = {DW'(dd), DW'(du)};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input bit with_stall);
    @(posedge clk);
    #2;
    rst = 1; i_valid = 0; i_stall = with_stall;
    @(posedge clk);
    #2;
    rst = 0; i_stall = 0;
  endtask

  task automatic wait_neg(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < target && guard < 200);
    if (cyc != target) check("wait_timeout", cyc, target);
  endtask

  typedef struct {
    bit sel; bit last; int au; int ad; int du; int dd; int eu; int ed; bit ebw;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int hits[$];
    tbl[0] = '{0, 0,   3, 131,  100,  200,  100,  200, 0};
    tbl[1] = '{1, 1,   5,   6,    1, 3328, 3303,   26, 1};
    tbl[2] = '{1, 1,   7,   8, 4095, 3329,   58,    0, 1};
    tbl[3] = '{1, 1,   9,  10,    2,    0, 3277,    0, 1};
    tbl[4] = '{1, 0,  11,  12, 1000, 4095, 1000, 4095, 0};
    tbl[5] = '{0, 1, 255,   0, 4095,    1, 4095,    1, 1};
    tbl[6] = '{0, 0,  17,  17,    5,    6,    5,    6, 0};

    // Power-on reset and reset state.
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    check("reset_rf_we", rf_we, 0);
    check("reset_bram_we", bram_we, 0);
    check("reset_rf_addr", rf_addr, 0);
    check("reset_rf_din", rf_din, 0);
    check("reset_bram_din", bram_din, 0);
    check("reset_wcount", o_wcount, 0);
    check("reset_busy", o_busy, 0);
    check("reset_ready", o_ready, 1);

    // Single isolated beats with hand-computed results.
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, tbl[i].last, tbl[i].sel, tbl[i].au, tbl[i].ad, tbl[i].du, tbl[i].dd);
      t0 = cyc;
      idle();
      wait_neg(t0 + 6);
      check($sformatf("tbl%0d_rf_we", i), rf_we, 2'b11);
      check($sformatf("tbl%0d_bram_we", i), bram_we, {tbl[i].ebw, tbl[i].ebw});
      check($sformatf("tbl%0d_rf_addr", i), rf_addr, {AW'(tbl[i].ad), AW'(tbl[i].au)});
      check($sformatf("tbl%0d_rf_din", i), rf_din, {DW'(tbl[i].ed), DW'(tbl[i].eu)});
      if (tbl[i].ebw)
        check($sformatf("tbl%0d_bram_din", i), bram_din, {BW'(tbl[i].ed), BW'(tbl[i].eu)});
      wait_neg(t0 + 7);
      check($sformatf("tbl%0d_we_one_cycle", i), rf_we, 2'b00);
    end

    // NTT beat followed directly by an INTT last-stage beat.
    drive(1, 0, 0, 0, 20, 21, 50, 60);
    t0 = cyc;
    drive(1, 0, 1, 1, 22, 23, 1, 2);
    idle();
    wait_neg(t0 + 6);
    check("b2b_first_din", rf_din, {DW'(60), DW'(50)});
    check("b2b_first_bwe", bram_we, 2'b00);
    wait_neg(t0 + 7);
    check("b2b_second_we", rf_we, 2'b11);
    check("b2b_second_din", rf_din, {DW'(3277), DW'(3303)});
    check("b2b_second_bwe", bram_we, 2'b11);

    // Three stalled edges with two beats in flight.
    drive(1, 0, 0, 0, 30, 31, 70, 71);
    t0 = cyc;
    drive(1, 0, 0, 0, 32, 33, 72, 73);
    for (int s = 0; s < 3; s++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      #1;
      check("stall_ready", o_ready, 0);
    end
    idle();
    #1;
    check("unstall_ready", o_ready, 1);
    hits.delete();
    while (cyc < t0 + 14) begin
      @(negedge clk);
      if (rf_we != 2'b00) hits.push_back(cyc);
    end
    check("stall_write_count", hits.size(), 2);
    if (hits.size() >= 2) begin
      check("stall_first_cycle", hits[0], t0 + 9);
      check("stall_second_cycle", hits[1], t0 + 10);
    end

    // Reset (with stall asserted) while three beats are in flight.
    drive(1, 0, 1, 1, 40, 41, 80, 81);
    t0 = cyc;
    drive(1, 0, 1, 0, 42, 43, 82, 83);
    drive(1, 0, 0, 0, 44, 45, 84, 85);
    @(negedge clk);
    check("pre_reset_busy", o_busy, 1);
    do_reset(1);
    wait_neg(t0 + 4);
    check("midreset_busy", o_busy, 0);
    check("midreset_rf_din", rf_din, 0);
    check("midreset_rf_addr", rf_addr, 0);
    check("midreset_bram_din", bram_din, 0);
    check("midreset_bram_addr", bram_addr, 0);
    check("midreset_wcount", o_wcount, 0);
    check("midreset_done", o_done, 0);
    hits.delete();
    while (cyc < t0 + 14) begin
      @(negedge clk);
      if (rf_we != 2'b00 || bram_we != 2'b00) hits.push_back(cyc);
    end
    check("post_reset_strobes", hits.size(), 0);

    // Full transform: 128 last-stage NTT beats back to back.
    do_reset(0);
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 0; k < 128; k++) drive(1, 0, 1, 0, 2*k, 2*k + 1, k, k + 1000);
    t0 = cyc;
    idle();
    wait_neg(t0 + 12);
    check("full_done_pulses", done_cnt, 1);
    check("full_done_cycle", done_cyc, t0 + 7);
    check("full_wcount_after", o_wcount, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    repeat (12) idle();
    @(negedge clk);
    check("final_busy", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_multilane.md
WB_MULTILANE -- requirements
Module: wb_multilane

Interface
REQ-001 Parameters SHALL be (name, default, meaning): LANES, 1, butterfly lanes per beat; DW, 12, coefficient width; AW, 8, address width; BW, 16, BRAM word width (BW>=DW); Q, 3329, modulus; NINV, 3303, INTT scale factor; MUL_LATENCY, 4, scaling pipeline depth (>=1); NCOEF, 256, coefficients per transform (multiple of 2*LANES).
REQ-002 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  beat offered
o_ready  out  1  beat may be accepted (= !i_stall)
i_stall  in  1  downstream hold; freezes pipeline
i_last  in  1  beat belongs to last stage
i_sel  in  1  0 NTT, 1 INTT
i_addr  in  2*LANES*AW  per lane {dn,up} addresses, lane 0 in LSBs
i_data  in  2*LANES*DW  per lane {dn,up} butterfly outputs
rf_we  out  2*LANES  regfile write strobes
rf_addr  out  2*LANES*AW  regfile addresses
rf_din  out  2*LANES*DW  regfile data
bram_we  out  2*LANES  BRAM write strobes
bram_addr  out  2*LANES*AW  BRAM addresses
bram_din  out  2*LANES*BW  BRAM data, zero-extended
o_done  out  1  one-cycle pulse: transform fully written to BRAM
o_busy  out  1  any beat in flight
o_wcount  out  AW+1  last-stage coefficients written

Function
REQ-004 A beat SHALL be accepted when i_valid && o_ready; nothing is sampled otherwise.
REQ-005 Every accepted beat (NTT and INTT alike) SHALL traverse one uniform pipeline of MUL_LATENCY stages carrying valid, last, sel, addresses and data, so outputs never collide and no beat is dropped.
REQ-006 Writes for a beat accepted at edge k SHALL appear on outputs, registered, during the cycle after edge k+MUL_LATENCY+1 when no stall occurs; each stalled cycle adds one cycle.
REQ-007 While i_stall=1 all pipeline stages, write strobes (forced 0), counters and o_done SHALL hold; addresses/data outputs hold their values.
REQ-008 Output slot j (0..2*LANES-1) SHALL carry word j of the beat; rf_we[j] and bram_we[j] assert for exactly one cycle per beat.
REQ-009 sel=0, last=0: rf writes of unscaled data; no BRAM write.
REQ-010 sel=0, last=1: rf and BRAM writes of unscaled data, same address.
REQ-011 sel=1, last=0: rf writes of unscaled data; no BRAM write.
REQ-012 sel=1, last=1: rf and BRAM writes of (data*NINV) mod Q; product width 2*DW, result < Q for any input 0..2^DW-1.
REQ-013 o_wcount SHALL increase by 2*LANES on each last-stage output cycle; when it reaches NCOEF, o_done SHALL pulse in the next cycle and o_wcount SHALL return to 0 in that same cycle.
REQ-014 A last-stage beat arriving in the cycle o_done pulses SHALL count toward the next transform (count = 2*LANES).
REQ-015 o_busy SHALL be 1 whenever any pipeline stage or output register holds a valid beat.
REQ-016 Lanes SHALL be independent; identical addresses across lanes are written as presented (no arbitration).

Reset
REQ-017 With rst=1 at an edge: all pipeline valid bits, rf_we, bram_we, o_done, o_busy, o_wcount SHALL become 0; rf_addr, rf_din, bram_addr, bram_din SHALL become 0.
REQ-018 Beats in flight at reset SHALL be discarded with no writes emitted; reset overrides i_stall.

Verification (defaults, LANES=1, latency L=MUL_LATENCY+1=5)
REQ-019 NTT non-last beat addr up=3/dn=131, data 100/200 -> 5 cycles later rf_we=2'b11, rf_addr 3/131, rf_din 100/200; bram_we=0.
REQ-020 INTT last beat data up=1/dn=3328 -> rf_din 3303/26, bram_din 0x0CE7/0x001A, both strobes high one cycle.
REQ-021 NTT beat then INTT-last beat on consecutive cycles -> two consecutive output cycles, both beats written, order preserved.
REQ-022 i_stall=1 for 3 cycles with 2 beats in flight -> no strobes during stall, o_ready=0, writes resume with latency 5+3.
REQ-023 128 NTT-last beats back to back -> o_wcount steps by 2, o_done single pulse after 128th write, o_wcount=0 after.
REQ-024 rst asserted with 3 beats in flight -> no subsequent strobes, all outputs 0, o_busy=0 next cycle.
